mem_access_stage: RTL and testbench

//  MEM stage directly downstream of the EXE/MEM register: consumes mem_* fields (incl. resolved
//  mem_branch/mem_bpc), runs a req/ack data-memory transaction, stalls upstream while a transaction
//  is outstanding, issues PC redirect + flush, and holds the MEM/WB pipeline register feeding WB.

---
 rtl/mem_access_stage_pkg.sv | 14 +
 rtl/mem_wb_register.sv | 58 +++++
 rtl/mem_access_stage.sv | 132 +++++++++++++
 tb/tb_mem_access_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: FSM state encoding, register-index width and defaults.
package mem_access_stage_pkg;

    localparam int RN_W             = 5;
    localparam int DEFAULT_DW       = 32;
    localparam int DEFAULT_MAX_WAIT = 15;
    localparam int DEFAULT_CNT_W    = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: loads the completed MEM result, or a bubble that suppresses write-back.
module mem_wb_register
    import mem_access_stage_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bubble_i,
    input  logic            mo_load_i,
    input  logic            wreg_i,
    input  logic            m2reg_i,
    input  logic [DW-1:0]   mo_i,
    input  logic [DW-1:0]   alu_i,
    input  logic [RN_W-1:0] rn_i,
    output logic            wreg_o,
    output logic            m2reg_o,
    output logic [DW-1:0]   mo_o,
    output logic [DW-1:0]   alu_o,
    output logic [RN_W-1:0] rn_o
);

    logic            wreg_q;
    logic            m2reg_q;
    logic [DW-1:0]   mo_q;
    logic [DW-1:0]   alu_q;
    logic [RN_W-1:0] rn_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
            mo_q    <= '0;
            alu_q   <= '0;
            rn_q    <= '0;
        end else if (bubble_i) begin
            // Bubble only kills the write-back controls; data fields keep their old contents.
            wreg_q  <= 1'b0;
            m2reg_q <= 1'b0;
        end else begin
            wreg_q  <= wreg_i;
            m2reg_q <= m2reg_i;
            alu_q   <= alu_i;
            rn_q    <= rn_i;
            if (mo_load_i) begin
                mo_q <= mo_i;
            end
        end
    end

    assign wreg_o  = wreg_q;
    assign m2reg_o = m2reg_q;
    assign mo_o    = mo_q;
    assign alu_o   = alu_q;
    assign rn_o    = rn_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: req/ack data-memory handshake with timeout, upstream stall, branch redirect, MEM/WB reg.
// Optional misaligned-access abort is built when MEM_ALIGN_CHECK_EN is defined.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DW       = DEFAULT_DW,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_wreg,
    input  logic            mem_m2reg,
    input  logic            mem_wmem,
    input  logic [DW-1:0]   mem_alu,
    input  logic [DW-1:0]   mem_b,
    input  logic [RN_W-1:0] mem_rn,
    input  logic            mem_branch,
    input  logic [DW-1:0]   mem_bpc,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [DW-1:0]   dmem_addr,
    output logic [DW-1:0]   dmem_wdata,
    input  logic [DW-1:0]   dmem_rdata,
    input  logic            dmem_ack,
    output logic            mem_stall,
    output logic            pc_redirect,
    output logic [DW-1:0]   redirect_pc,
    output logic            flush,
    output logic            mem_err,
    output logic            wb_wreg,
    output logic            wb_m2reg,
    output logic [DW-1:0]   wb_mo,
    output logic [DW-1:0]   wb_alu,
    output logic [RN_W-1:0] wb_rn
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             acc, misalign, abort, req_c, complete, bubble;

    assign acc = mem_m2reg | mem_wmem;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = acc & (mem_alu[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_c   = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_c = acc & ~misalign;
                cnt_d = '0;
                if (req_c & ~dmem_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dmem_ack) begin
                    req_c   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(MAX_WAIT)) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    req_c = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Upstream-facing controls drop as soon as reset asserts, without waiting for an edge.
    assign dmem_req    = ~rst & req_c;
    assign mem_stall   = ~rst & acc & ~dmem_ack & ~abort & ~misalign;
    assign pc_redirect = ~rst & mem_branch & ~mem_stall;
    assign flush       = pc_redirect;
    assign redirect_pc = mem_bpc;
    assign dmem_we     = mem_wmem;
    assign dmem_addr   = mem_alu;
    assign dmem_wdata  = mem_b;

    assign complete = req_c & dmem_ack;
    assign bubble   = mem_stall | abort | misalign;
    assign err_d    = abort | misalign;
    assign mem_err  = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    mem_wb_register #(
        .DW (DW)
    ) u_mem_wb (
        .clk       (clk),
        .rst       (rst),
        .bubble_i  (bubble),
        .mo_load_i (complete & mem_m2reg),
        .wreg_i    (mem_wreg),
        .m2reg_i   (mem_m2reg),
        .mo_i      (dmem_rdata),
        .alu_i     (mem_alu),
        .rn_i      (mem_rn),
        .wreg_o    (wb_wreg),
        .m2reg_o   (wb_m2reg),
        .mo_o      (wb_mo),
        .alu_o     (wb_alu),
        .rn_o      (wb_rn)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vectors, literal checks, and a cycle-level behavioural model.
module tb_mem_access_stage;

    localparam int DW       = 32;
    localparam int MAX_WAIT = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mem_wreg = 1'b0, mem_m2reg = 1'b0, mem_wmem = 1'b0;
    logic [DW-1:0]   mem_alu = '0, mem_b = '0, mem_bpc = '0;
    logic [4:0]      mem_rn = '0;
    logic            mem_branch = 1'b0;
    logic [DW-1:0]   dmem_rdata = '0;
    logic            dmem_ack = 1'b0;
    logic            dmem_req, dmem_we, mem_stall, pc_redirect, flush, mem_err;
    logic [DW-1:0]   dmem_addr, dmem_wdata, redirect_pc;
    logic            wb_wreg, wb_m2reg;
    logic [DW-1:0]   wb_mo, wb_alu;
    logic [4:0]      wb_rn;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(
        .DW       (DW),
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_wreg    (mem_wreg),
        .mem_m2reg   (mem_m2reg),
        .mem_wmem    (mem_wmem),
        .mem_alu     (mem_alu),
        .mem_b       (mem_b),
        .mem_rn      (mem_rn),
        .mem_branch  (mem_branch),
        .mem_bpc     (mem_bpc),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_ack    (dmem_ack),
        .mem_stall   (mem_stall),
        .pc_redirect (pc_redirect),
        .redirect_pc (redirect_pc),
        .flush       (flush),
        .mem_err     (mem_err),
        .wb_wreg     (wb_wreg),
        .wb_m2reg    (wb_m2reg),
        .wb_mo       (wb_mo),
        .wb_alu      (wb_alu),
        .wb_rn       (wb_rn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks how many cycles the current access has already stalled; the access is abandoned
    // once it has stalled MAX_WAIT+1 cycles without an ack.
    int          m_stalled = 0;
    logic        m_err = 1'b0, m_wreg = 1'b0, m_m2reg = 1'b0;
    logic [31:0] m_mo = '0, m_alu = '0;
    logic [4:0]  m_rn = '0;

    always @(negedge clk) begin
        logic acc, mis, ab, rq, st, rd;
        if (rst) begin
            m_stalled = 0; m_err = 1'b0; m_wreg = 1'b0; m_m2reg = 1'b0;
            m_mo = '0; m_alu = '0; m_rn = '0;
        end
        acc = mem_m2reg | mem_wmem;
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = acc && (mem_alu % 4 != 0);
`endif
        ab = acc && !mis && !dmem_ack && (m_stalled == MAX_WAIT + 1);
        rq = !rst && acc && !mis && !ab;
        st = !rst && acc && !mis && !dmem_ack && !ab;
        rd = !rst && mem_branch && !st;

        check("m_req",      dmem_req,    rq);
        check("m_stall",    mem_stall,   st);
        check("m_redirect", pc_redirect, rd);
        check("m_flush",    flush,       rd);
        check("m_rpc",      redirect_pc, mem_bpc);
        check("m_we",       dmem_we,     mem_wmem);
        check("m_addr",     dmem_addr,   mem_alu);
        check("m_wdata",    dmem_wdata,  mem_b);
        check("m_err",      mem_err,     m_err);
        check("m_wb_wreg",  wb_wreg,     m_wreg);
        check("m_wb_m2reg", wb_m2reg,    m_m2reg);
        check("m_wb_mo",    wb_mo,       m_mo);
        check("m_wb_alu",   wb_alu,      m_alu);
        check("m_wb_rn",    wb_rn,       32'(m_rn));

        if (!rst) begin
            m_err     = ab || mis;
            m_stalled = st ? m_stalled + 1 : 0;
            if (st || ab || mis) begin
                m_wreg = 1'b0; m_m2reg = 1'b0;
            end else begin
                m_wreg = mem_wreg; m_m2reg = mem_m2reg; m_alu = mem_alu; m_rn = mem_rn;
                if (mem_m2reg && dmem_ack) m_mo = dmem_rdata;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wreg, input logic m2reg, input logic wmem,
                         input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                         input logic br, input logic [31:0] bpc,
                         input logic ack, input logic [31:0] rdata);
        mem_wreg = wreg; mem_m2reg = m2reg; mem_wmem = wmem;
        mem_alu = alu; mem_b = b; mem_rn = rn;
        mem_branch = br; mem_bpc = bpc;
        dmem_ack = ack; dmem_rdata = rdata;
    endtask

    task automatic idle_in(input logic ack);
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0, ack, 32'h0);
    endtask

    initial begin
        int  stalls;
        bit  done;

        // Reset state
        step(); step();
        @(negedge clk);
        check("rst_req",   dmem_req,  0);
        check("rst_stall", mem_stall, 0);
        check("rst_err",   mem_err,   0);
        check("rst_wreg",  wb_wreg,   0);
        step(); rst = 1'b0;

        // 1: zero-wait load
        drive(1, 1, 0, 32'h40, 32'h0, 5'd7, 0, 32'h0, 1, 32'hDEADBEEF);
        @(negedge clk);
        check("t1_stall", mem_stall, 0);
        check("t1_req",   dmem_req,  1);
        step(); drive(1, 0, 0, 32'h55, 32'h0, 5'd3, 0, 32'h0, 1, 32'h11111111);
        @(negedge clk);
        check("t1_wb_mo",   wb_mo,   32'hDEADBEEF);
        check("t1_wb_rn",   wb_rn,   7);
        check("t1_wb_wreg", wb_wreg, 1);
        check("t1_req_noacc", dmem_req, 0);
        step(); idle_in(0);
        @(negedge clk);
        check("t1_ack_ignored_mo", wb_mo,  32'hDEADBEEF);
        check("t1_alu_pass",       wb_alu, 32'h55);

        // 2: store with three wait states
        step(); drive(0, 0, 1, 32'h80, 32'h1234, 5'd0, 0, 32'h0, 0, 32'h0);
        stalls = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            if (i == 3) dmem_ack = 1'b1;
            @(negedge clk);
            if (mem_stall) stalls++;
            check("t2_req",   dmem_req,   1);
            check("t2_we",    dmem_we,    1);
            check("t2_addr",  dmem_addr,  32'h80);
            check("t2_wdata", dmem_wdata, 32'h1234);
        end
        check("t2_stalls", stalls, 3);
        step(); idle_in(0);
        @(negedge clk);
        check("t2_wb_wreg", wb_wreg, 0);

        // 3: timeout, then a late ack that must be ignored
        step(); drive(1, 1, 0, 32'h44, 32'h0, 5'd9, 0, 32'h0, 0, 32'h0);
        stalls = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (i > 0) step();
            @(negedge clk);
            if (mem_stall) stalls++;
            else begin
                done = 1;
                check("t3_abort_req", dmem_req, 0);
                check("t3_abort_err_not_yet", mem_err, 0);
            end
        end
        check("t3_bound", done, 1);
        check("t3_stalls", stalls, MAX_WAIT + 1);
        step(); idle_in(1);
        @(negedge clk);
        check("t3_err",     mem_err, 1);
        check("t3_wb_wreg", wb_wreg, 0);
        check("t3_mo_kept", wb_mo,   32'hDEADBEEF);
        step(); idle_in(0);
        @(negedge clk);
        check("t3_err_pulse", mem_err, 0);

        // 4: branch, then branch combined with a one-wait load
        step(); drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 1, 32'h100, 0, 32'h0);
        @(negedge clk);
        check("t4_redirect", pc_redirect, 1);
        check("t4_flush",    flush,       1);
        check("t4_rpc",      redirect_pc, 32'h100);
        check("t4_req",      dmem_req,    0);
        step(); idle_in(0);
        @(negedge clk);
        check("t4_redirect_off", pc_redirect, 0);
        step(); drive(1, 1, 0, 32'h60, 32'h0, 5'd2, 1, 32'h200, 0, 32'h0);
        @(negedge clk);
        check("t4_held_redirect", pc_redirect, 0);
        step(); dmem_ack = 1'b1; dmem_rdata = 32'hA5A5_0001;
        @(negedge clk);
        check("t4_late_redirect", pc_redirect, 1);
        step(); idle_in(0);
        @(negedge clk);
        check("t4_wb_mo", wb_mo, 32'hA5A5_0001);

        // 5: reset in the second WAIT cycle
        step(); drive(1, 1, 0, 32'h48, 32'h0, 5'd5, 0, 32'h0, 0, 32'h0);
        @(negedge clk);
        check("t5_stall", mem_stall, 1);
        step(); #2 rst = 1'b1;
        @(negedge clk);
        check("t5_req",   dmem_req, 0);
        check("t5_wreg",  wb_wreg,  0);
        check("t5_m2reg", wb_m2reg, 0);
        check("t5_mo",    wb_mo,    0);
        check("t5_alu",   wb_alu,   0);
        check("t5_rn",    wb_rn,    0);
        check("t5_err",   mem_err,  0);
        step(); idle_in(0); rst = 1'b0;
        step(); drive(1, 1, 0, 32'h4C, 32'h0, 5'd6, 0, 32'h0, 1, 32'h0BAD_F00D);
        @(negedge clk);
        check("t5_idle_req",   dmem_req,  1);
        check("t5_idle_stall", mem_stall, 0);
        step(); idle_in(0);
        @(negedge clk);
        check("t5_after_mo", wb_mo, 32'h0BAD_F00D);

        // 6: misaligned load
        step(); drive(1, 1, 0, 32'h42, 32'h0, 5'd4, 0, 32'h0, 1, 32'hCAFEF00D);
        @(negedge clk);
`ifdef MEM_ALIGN_CHECK_EN
        check("t6_req",   dmem_req,  0);
        check("t6_stall", mem_stall, 0);
        step(); idle_in(0);
        @(negedge clk);
        check("t6_err",  mem_err, 1);
        check("t6_wreg", wb_wreg, 0);
`else
        check("t6_req",  dmem_req,  1);
        check("t6_addr", dmem_addr, 32'h42);
        step(); idle_in(0);
        @(negedge clk);
        check("t6_err", mem_err, 0);
        check("t6_mo",  wb_mo,   32'hCAFEF00D);
`endif
        step(); idle_in(0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (bad=%0d)", bad);
        $fatal(1, "watchdog");
    end

endmodule
